sonar_scheduler: RTL

Measurement sequencer and bus register block for the HC-SR04 ultrasonic level sensor on the pump-control SoC. It generates trigger pulses on demand or back-to-back in auto mode, synchronises and times the echo, and converts the pulse width to centimetres. It enforces echo timeout and inter-shot holdoff, and exposes control, status and distance through the peripheral bus used by the firmware.

---
 rtl/sonar_scheduler.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/sonar_scheduler.sv
// HC-SR04 measurement sequencer: trigger generation, echo timing, cm conversion,
// timeout/holdoff enforcement and a small control/status register block.
`timescale 1ns/1ps
module sonar_scheduler #(
  parameter int TRIG_CYCLES    = 500,
  parameter int ECHO_TIMEOUT   = 1_900_000,
  parameter int HOLDOFF_CYCLES = 3_000_000,
  parameter int CM_DIV         = 2900
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cs,
  input  logic        rd,
  input  logic        wr,
  input  logic [4:0]  addr,
  input  logic [31:0] d_in,
  output logic [31:0] d_out,
  input  logic        echo,
  output logic        trigger,
  output logic        busy
);

  localparam int CNT_MAX0 = (TRIG_CYCLES > ECHO_TIMEOUT) ? TRIG_CYCLES : ECHO_TIMEOUT;
  localparam int CNT_MAX  = (CNT_MAX0 > HOLDOFF_CYCLES) ? CNT_MAX0 : HOLDOFF_CYCLES;
  localparam int CNT_W    = $clog2(CNT_MAX + 1);
  localparam int SUB_W    = (CM_DIV > 1) ? $clog2(CM_DIV) : 1;

  localparam logic [CNT_W-1:0] TRIG_LAST = CNT_W'(TRIG_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(ECHO_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLDOFF_CYCLES - 1);
  localparam logic [SUB_W-1:0] SUB_LAST  = SUB_W'(CM_DIV - 1);

  localparam logic [4:0] A_CTRL = 5'h00;
  localparam logic [4:0] A_DIST = 5'h01;
  localparam logic [4:0] A_STAT = 5'h02;

  typedef enum logic [2:0] {IDLE, TRIG, WAIT_RISE, MEASURE, HOLDOFF} state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [SUB_W-1:0]  sub_cnt;
  logic [15:0]       cm_cnt;
  logic [15:0]       distance;
  logic              valid, timeout, auto_en, start_pending;
  logic              echo_s1, echo_s2, echo_d;
  logic              echo_rise, echo_fall, go, start_wr, ctrl_wr, rd_dist, enter_trig;
  logic              unused_bits;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFE) ? v : v + 16'd1;
  endfunction

  // One echo-high cycle: advance sub-counter, carry into the saturating cm count.
  function automatic logic [SUB_W+15:0] cm_step(input logic [SUB_W-1:0] sub,
                                                input logic [15:0] cm);
    if (sub == SUB_LAST) return {sat_inc(cm), {SUB_W{1'b0}}};
    return {cm, sub + 1'b1};
  endfunction

  assign echo_rise  = echo_s2 && !echo_d;
  assign echo_fall  = !echo_s2 && echo_d;
  assign go         = start_pending || auto_en;
  assign ctrl_wr    = cs && wr && (addr == A_CTRL);
  assign start_wr   = ctrl_wr && d_in[1];
  assign rd_dist    = cs && rd && (addr == A_DIST);
  assign enter_trig = go && ((state == IDLE) || ((state == HOLDOFF) && (cnt == HOLD_LAST)));
  assign busy       = (state != IDLE);
  assign unused_bits = ^d_in[31:2];

  always_ff @(posedge clk) begin
    if (rst) begin
      echo_s1 <= 1'b0;
      echo_s2 <= 1'b0;
      echo_d  <= 1'b0;
    end else begin
      echo_s1 <= echo;
      echo_s2 <= echo_s1;
      echo_d  <= echo_s2;
    end
  end

  // Sequencer; trigger is decoded from the registered state, one cycle behind it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      sub_cnt  <= '0;
      cm_cnt   <= '0;
      trigger  <= 1'b0;
      distance <= '0;
      valid    <= 1'b0;
      timeout  <= 1'b0;
    end else begin
      trigger <= (state == TRIG);
      if (rd_dist) valid <= 1'b0;
      case (state)
        IDLE: begin
          if (go) begin
            state <= TRIG;
            cnt   <= '0;
          end
        end
        TRIG: begin
          if (cnt == TRIG_LAST) begin
            state <= WAIT_RISE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        WAIT_RISE: begin
          if (echo_rise) begin
            // The edge cycle itself is already an echo-high cycle.
            state             <= MEASURE;
            cnt               <= '0;
            {cm_cnt, sub_cnt} <= cm_step('0, '0);
          end else if (cnt == TMO_LAST) begin
            state    <= HOLDOFF;
            cnt      <= '0;
            distance <= 16'hFFFF;
            valid    <= 1'b1;
            timeout  <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        MEASURE: begin
          if (echo_fall) begin
            state    <= HOLDOFF;
            cnt      <= '0;
            distance <= cm_cnt;
            valid    <= 1'b1;
            timeout  <= 1'b0;
          end else if (cnt == TMO_LAST) begin
            state    <= HOLDOFF;
            cnt      <= '0;
            distance <= 16'hFFFF;
            valid    <= 1'b1;
            timeout  <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
            if (echo_s2) {cm_cnt, sub_cnt} <= cm_step(sub_cnt, cm_cnt);
          end
        end
        HOLDOFF: begin
          if (cnt == HOLD_LAST) begin
            state <= go ? TRIG : IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Bus side: entering TRIG consumes a pending start even if a new one lands now.
  always_ff @(posedge clk) begin
    if (rst) begin
      d_out         <= '0;
      auto_en       <= 1'b0;
      start_pending <= 1'b0;
    end else begin
      if (ctrl_wr) auto_en <= d_in[0];
      if (enter_trig)    start_pending <= 1'b0;
      else if (start_wr) start_pending <= 1'b1;
      if (cs && rd) begin
        case (addr)
          A_CTRL:  d_out <= {31'd0, auto_en};
          A_DIST:  d_out <= {16'd0, distance};
          A_STAT:  d_out <= {29'd0, timeout, valid, busy};
          default: d_out <= '0;
        endcase
      end
    end
  end

endmodule
